// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

  // Elaboration-time helper for the digit-capacity check.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the dabble step: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);
  // 4-bit wrap is intended; a digit <=9 never carries after adjustment.
  assign dout = (din >= DIGIT_W'(ADJ_THRESH)) ? din + DIGIT_W'(ADJ_ADD) : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one bit per clock, start/done handshake.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd
);
  localparam int SCR_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (pow10(DIGITS) <= (longint'(1) << BIN_W) - 1) begin : g_cap_chk
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  state_t             state, state_nxt;
  logic [SCR_W-1:0]   scratch, adj, scr_nxt;
  logic [BIN_W-1:0]   shreg, sh_nxt;
  logic [CNT_W-1:0]   count;
  logic               accept;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[d*DIGIT_W +: DIGIT_W]),
      .dout (adj[d*DIGIT_W +: DIGIT_W])
    );
  end

  // Adjust first, then shift the shift-reg MSB into the scratch LSB.
  assign scr_nxt = {adj[SCR_W-2:0], shreg[BIN_W-1]};
  assign sh_nxt  = shreg << 1;

  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (count == '0) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= '0;
      shreg   <= '0;
      count   <= '0;
      bcd     <= '0;
    end else if (accept) begin
      scratch <= '0;
      shreg   <= bin;
      count   <= CNT_W'(BIN_W - 1);
    end else if (state == SHIFT) begin
      scratch <= scr_nxt;
      shreg   <= sh_nxt;
      if (count == '0) bcd   <= scr_nxt;
      else             count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, corner sequences, exhaustive sweep.
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  bin;
  logic        busy, done;
  logic [11:0] bcd;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [11:0] sb[$];
  logic [11:0] last_bcd = '0;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vec_t;
  vec_t tbl[8];

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard monitor: every done pops one expectation; bcd must hold otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else                chk("done_bcd", bcd, sb.pop_front());
      end else if (bcd !== last_bcd) begin
        chk("bcd_stable", bcd, last_bcd);
      end
    end
    last_bcd = bcd;
  end

  task automatic wait_ready();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    if (busy) chk("ready_timeout", 1, 0);
  endtask

  task automatic wait_done(output int at);
    int i;
    for (i = 0; i < 40 && !done; i++) @(negedge clk);
    if (!done) chk("done_timeout", 0, 1);
    at = cyc;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
  endtask

  // Called at a negedge; drives one start pulse and records the expectation.
  task automatic do_conv(input logic [7:0] v, input logic [11:0] e);
    wait_ready();
    start = 1'b1; bin = v; sb.push_back(e);
    @(negedge clk);
    start = 1'b0; bin = 8'($urandom);
  endtask

  initial begin
    int t1, t2;
    tbl[0] = '{8'd255, 12'h255};
    tbl[1] = '{8'd0,   12'h000};
    tbl[2] = '{8'd99,  12'h099};
    tbl[3] = '{8'd100, 12'h100};
    tbl[4] = '{8'd1,   12'h001};
    tbl[5] = '{8'd128, 12'h128};
    tbl[6] = '{8'd9,   12'h009};
    tbl[7] = '{8'd250, 12'h250};

    rst_n = 1'b0; start = 1'b0; bin = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd",  bcd,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: busy for 8 cycles, done after edge N+8.
    start = 1'b1; bin = 8'd255; sb.push_back(12'h255);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin start = 1'b0; bin = 8'd3; end
      chk("lat_busy", busy, 1);
      chk("lat_nodone", done, 0);
    end
    @(negedge clk);
    chk("lat_done", done, 1);
    chk("lat_busy_low", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    for (int i = 0; i < 8; i++) do_conv(tbl[i].bin, tbl[i].bcd);
    drain();

    // start held through conversion, bin changed mid-run; re-accept only in DONE.
    wait_ready();
    start = 1'b1; bin = 8'd123; sb.push_back(12'h123);
    repeat (3) @(negedge clk);
    bin = 8'd7;
    wait_done(t1);
    sb.push_back(12'h007);
    @(negedge clk);
    start = 1'b0;
    chk("held_reaccept_busy", busy, 1);
    wait_done(t2);
    chk("held_spacing", t2 - t1, 9);
    drain();

    // Back-to-back start in DONE cycle.
    do_conv(8'd77, 12'h077);
    wait_done(t1);
    start = 1'b1; bin = 8'd42; sb.push_back(12'h042);
    @(negedge clk);
    start = 1'b0;
    wait_done(t2);
    chk("b2b_spacing", t2 - t1, 9);
    drain();

    // Asynchronous reset mid-conversion.
    wait_ready();
    start = 1'b1; bin = 8'd200; sb.push_back(12'h200);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_bcd",  bcd,  0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_conv(8'd200, 12'h200);
    drain();

    for (int v = 0; v < 256; v++) do_conv(8'(v), ref_bcd(v));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
